// File: rtl/bound_flasher_pkg.sv
`default_nettype none
// bound_flasher_pkg -- sequencer state type, level-width helper, default sweep table.
// Rev 1.0
package bound_flasher_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic int lw_f(input int n_led);
    return $clog2(n_led + 1);
  endfunction

  localparam int DEF_N_LED   = 16;
  localparam int DEF_N_PHASE = 6;
  // Phase 0 in the LSBs: 16, 6, 11, 0, 6, 0
  localparam logic [29:0] DEF_PH_TARGET = {5'd0, 5'd6, 5'd0, 5'd11, 5'd6, 5'd16};
  localparam logic [16:0] DEF_KICK_MASK = 17'h00041;

endpackage
`default_nettype wire

// File: rtl/bound_flasher_gen_flick_sync.sv
`default_nettype none
// flick_sync -- two-flop synchroniser for the active-low flick button; clears to "not pressed".
// Rev 1.0
module flick_sync (
  input  logic clk,
  input  logic reset,
  input  logic flick,
  output logic pressed
);

  logic s1;
  logic s2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= flick;
      s2 <= s1;
    end
  end

  assign pressed = ~s2;

endmodule
`default_nettype wire

// File: rtl/bound_flasher_gen.sv
`default_nettype none
// bound_flasher_gen -- table-driven up/down thermometer lamp sequencer with kickback and looping.
// Rev 1.0
module bound_flasher_gen
  import bound_flasher_pkg::*;
#(
  parameter int                              N_LED     = DEF_N_LED,
  parameter int                              N_PHASE   = DEF_N_PHASE,
  parameter logic [N_PHASE*lw_f(N_LED)-1:0]  PH_TARGET = DEF_PH_TARGET,
  parameter logic [N_LED:0]                  KICK_MASK = DEF_KICK_MASK,
  parameter int                              DIV       = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flick,
  input  logic                       loop_en,
  output logic [N_LED-1:0]           lamp,
  output logic [lw_f(N_LED)-1:0]     level,
  output logic [$clog2(N_PHASE)-1:0] phase_idx,
  output logic                       busy,
  output logic                       done
);

  localparam int LW = lw_f(N_LED);
  localparam int PW = $clog2(N_PHASE);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  if (N_LED < 1 || N_PHASE < 2 || (N_PHASE % 2) != 0 || DIV < 1) begin : g_bad_param
    $error("bound_flasher_gen: N_LED, N_PHASE or DIV out of range");
  end

  // Each entry must move away from its predecessor in its sweep direction (wrapping for loops).
  for (genvar p = 0; p < N_PHASE; p++) begin : g_table_chk
    localparam int TGT  = int'(PH_TARGET[p*LW +: LW]);
    localparam int PREV = int'(PH_TARGET[((p == 0) ? N_PHASE - 1 : p - 1)*LW +: LW]);
    if (TGT > N_LED || (((p % 2) == 0) ? (TGT <= PREV) : (TGT >= PREV))) begin : g_bad_entry
      $error("bound_flasher_gen: PH_TARGET entry breaks range or alternation");
    end
  end

  state_t           state;
  state_t           state_n;
  logic [LW-1:0]    level_n;
  logic [LW-1:0]    tgt;
  logic [LW-1:0]    lvl_inc;
  logic [LW-1:0]    lvl_dec;
  logic [PW-1:0]    phase_n;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_n;
  logic [N_LED-1:0] lamp_n;
  logic             fl;
  logic             tick;
  logic             advance;
  logic             done_n;

  flick_sync u_sync (
    .clk     (clk),
    .reset   (reset),
    .flick   (flick),
    .pressed (fl)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      level     <= '0;
      phase_idx <= '0;
      cnt       <= '0;
      lamp      <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      level     <= level_n;
      phase_idx <= phase_n;
      cnt       <= cnt_n;
      lamp      <= lamp_n;
      done      <= done_n;
    end
  end

  assign tgt     = PH_TARGET[phase_idx*LW +: LW];
  assign tick    = (cnt == CW'(DIV - 1));
  assign lvl_inc = level + LW'(1);
  assign lvl_dec = level - LW'(1);

  always_comb begin
    state_n = state;
    level_n = level;
    phase_n = phase_idx;
    cnt_n   = cnt;
    done_n  = 1'b0;
    advance = 1'b0;
    case (state)
      IDLE: begin
        if (fl) begin
          state_n = RUN;
          phase_n = '0;
          cnt_n   = '0;
        end
      end
      RUN: begin
        cnt_n = tick ? '0 : cnt + CW'(1);
        if (tick) begin
          if (!phase_idx[0]) begin
            level_n = lvl_inc;
            advance = (lvl_inc == tgt);
          end else begin
            level_n = lvl_dec;
            // Kickback beats completion, so a held button can keep a run alive on the last phase
            if (KICK_MASK[lvl_dec] && fl) begin
              phase_n = phase_idx - PW'(1);
            end else begin
              advance = (lvl_dec == tgt);
            end
          end
          if (advance) begin
            if (phase_idx != PW'(N_PHASE - 1)) begin
              phase_n = phase_idx + PW'(1);
            end else if (loop_en) begin
              phase_n = '0;
            end else begin
              state_n = IDLE;
              level_n = '0;
              phase_n = '0;
              done_n  = 1'b1;
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  for (genvar k = 0; k < N_LED; k++) begin : g_therm
    assign lamp_n[k] = (level_n > LW'(k));
  end

  always_comb begin
    busy = (state == RUN);
  end

endmodule
`default_nettype wire

// File: tb/tb_bound_flasher_gen.sv
`default_nettype none
// tb_bound_flasher_gen -- scoreboard bench: expected level steps queued per scenario, popped on each DUT step.
// Rev 1.0
module tb_bound_flasher_gen;

  logic        clk     = 1'b0;
  logic        reset   = 1'b0;
  logic        flick   = 1'b1;
  logic        flick4  = 1'b1;
  logic        loop_en = 1'b0;
  logic        loop4   = 1'b0;
  logic [15:0] lamp, lamp4;
  logic [4:0]  level, level4;
  logic [2:0]  phase_idx, phase4;
  logic        busy, busy4, done, done4;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          exp_q[$];
  int          prev_level = 0;
  int          done_cnt = 0;
  int          sb_e;
  logic [15:0] sb_lamp;

  always #5 clk = ~clk;

  bound_flasher_gen dut (
    .clk(clk), .reset(reset), .flick(flick), .loop_en(loop_en),
    .lamp(lamp), .level(level), .phase_idx(phase_idx), .busy(busy), .done(done)
  );

  bound_flasher_gen #(.DIV(4)) dut4 (
    .clk(clk), .reset(reset), .flick(flick4), .loop_en(loop4),
    .lamp(lamp4), .level(level4), .phase_idx(phase4), .busy(busy4), .done(done4)
  );

  // Scoreboard consumer: every level change of dut must match the next queued level and its lamp bar
  always @(negedge clk) begin
    if (!reset) begin
      prev_level = int'(level);
    end else begin
      if (done) done_cnt++;
      if (int'(level) != prev_level) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_step: level moved %0d -> %0d, required no step", prev_level, level);
        end else begin
          sb_e    = exp_q.pop_front();
          sb_lamp = 16'((32'd1 << sb_e) - 32'd1);
          if (int'(level) !== sb_e || lamp !== sb_lamp) begin
            n_fail++;
            $display("FAIL sb_step: level %0d lamp %h, required level %0d lamp %h", level, lamp, sb_e, sb_lamp);
          end
        end
        prev_level = int'(level);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_ramp(input int from, input int to);
    int l;
    l = from;
    while (l != to) begin
      l += (to > from) ? 1 : -1;
      exp_q.push_back(l);
    end
  endtask

  task automatic push_table();
    push_ramp(0, 16); push_ramp(16, 6); push_ramp(6, 11);
    push_ramp(11, 0); push_ramp(0, 6);  push_ramp(6, 0);
  endtask

  task automatic press_start();
    @(negedge clk); flick = 1'b0;
    @(negedge clk); flick = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({lamp, level, phase_idx, busy, done, lamp4, level4, phase4, busy4, done4} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: lamp %h level %0d phase %0d busy %b done %b, required all 0",
               lamp, level, phase_idx, busy, done);
    end
    @(negedge clk); #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || level !== 5'd0) begin
      n_fail++;
      $display("FAIL idle_hold: busy %b level %0d, required 0 and 0", busy, level);
    end
  endtask

  task automatic test_full_run();
    int cyc;
    exp_q.delete(); done_cnt = 0;
    push_table();
    @(negedge clk); flick = 1'b0;
    @(negedge clk); flick = 1'b1;
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL busy_early: busy %b, required 0 one cycle after press", busy);
    end
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b1 || level !== 5'd0) begin
      n_fail++; $display("FAIL busy_start: busy %b level %0d, required 1 and 0", busy, level);
    end
    cyc = 0;
    while (!done && cyc < 200) begin @(negedge clk); cyc++; end
    #1;
    n_tests++;
    if (cyc != 54) begin
      n_fail++; $display("FAIL done_latency: %0d cycles, required 54", cyc);
    end
    n_tests++;
    if (busy !== 1'b0 || lamp !== 16'h0000 || level !== 5'd0 || phase_idx !== 3'd0) begin
      n_fail++;
      $display("FAIL done_state: busy %b lamp %h level %0d phase %0d, required 0 0000 0 0", busy, lamp, level, phase_idx);
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL full_steps: %0d steps missing, required 0", exp_q.size());
    end
    @(negedge clk); #1;
    n_tests++;
    if (done !== 1'b0 || done_cnt != 1) begin
      n_fail++; $display("FAIL done_pulse: done %b count %0d, required 0 and 1", done, done_cnt);
    end
  endtask

  task automatic test_kickback();
    int cyc;
    exp_q.delete(); done_cnt = 0;
    push_ramp(0, 16); push_ramp(16, 6); push_ramp(6, 16); push_ramp(16, 6);
    push_ramp(6, 11); push_ramp(11, 0); push_ramp(0, 6); push_ramp(6, 0);
    @(negedge clk); flick = 1'b0;
    cyc = 0; while (level != 16 && cyc < 100) begin @(negedge clk); cyc++; end
    cyc = 0; while (level != 6 && cyc < 100) begin @(negedge clk); cyc++; end
    n_tests++;
    if (phase_idx !== 3'd0 || level !== 5'd6) begin
      n_fail++; $display("FAIL kick_phase: phase %0d level %0d, required phase 0 level 6", phase_idx, level);
    end
    flick = 1'b1;
    cyc = 0; while (level != 16 && cyc < 100) begin @(negedge clk); cyc++; end
    n_tests++;
    if (phase_idx !== 3'd1 || level !== 5'd16) begin
      n_fail++; $display("FAIL kick_climb: phase %0d level %0d, required phase 1 level 16", phase_idx, level);
    end
    cyc = 0; while (level != 6 && cyc < 100) begin @(negedge clk); cyc++; end
    n_tests++;
    if (phase_idx !== 3'd2 || level !== 5'd6) begin
      n_fail++; $display("FAIL kick_resume: phase %0d level %0d, required phase 2 level 6", phase_idx, level);
    end
    cyc = 0; while (!done && cyc < 200) begin @(negedge clk); cyc++; end
    #1;
    n_tests++;
    if (exp_q.size() != 0 || done_cnt != 1) begin
      n_fail++; $display("FAIL kick_end: %0d steps missing, done count %0d, required 0 and 1", exp_q.size(), done_cnt);
    end
  endtask

  task automatic test_kick_last();
    int cyc;
    exp_q.delete(); done_cnt = 0;
    push_table(); push_ramp(0, 6); push_ramp(6, 0);
    press_start();
    cyc = 0; while (!(phase_idx == 3'd5 && level == 5'd3) && cyc < 200) begin @(negedge clk); cyc++; end
    flick = 1'b0;
    cyc = 0; while (level != 0 && cyc < 20) begin @(negedge clk); cyc++; end
    #1;
    n_tests++;
    if (phase_idx !== 3'd4 || busy !== 1'b1 || done !== 1'b0 || done_cnt != 0) begin
      n_fail++;
      $display("FAIL kick_last: phase %0d busy %b done %b count %0d, required 4 1 0 0", phase_idx, busy, done, done_cnt);
    end
    flick = 1'b1;
    cyc = 0; while (!done && cyc < 200) begin @(negedge clk); cyc++; end
    #1;
    n_tests++;
    if (exp_q.size() != 0 || done_cnt != 1) begin
      n_fail++; $display("FAIL kick_last_end: %0d steps missing, done count %0d, required 0 and 1", exp_q.size(), done_cnt);
    end
  endtask

  task automatic test_loop();
    int cyc;
    exp_q.delete(); done_cnt = 0;
    loop_en = 1'b1;
    push_table(); push_table();
    press_start();
    cyc = 0; while (phase_idx != 3'd5 && cyc < 200) begin @(negedge clk); cyc++; end
    cyc = 0; while (level != 0 && cyc < 50) begin @(negedge clk); cyc++; end
    #1;
    n_tests++;
    if (phase_idx !== 3'd0 || busy !== 1'b1 || done !== 1'b0 || done_cnt != 0) begin
      n_fail++;
      $display("FAIL loop_wrap: phase %0d busy %b done %b, required 0 1 0", phase_idx, busy, done);
    end
    loop_en = 1'b0;
    @(negedge clk);
    n_tests++;
    if (phase_idx !== 3'd0 || level !== 5'd1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL loop_restep: phase %0d level %0d busy %b, required 0 1 1", phase_idx, level, busy);
    end
    cyc = 0; while (!done && cyc < 200) begin @(negedge clk); cyc++; end
    #1;
    n_tests++;
    if (exp_q.size() != 0 || done_cnt != 1) begin
      n_fail++; $display("FAIL loop_end: %0d steps missing, done count %0d, required 0 and 1", exp_q.size(), done_cnt);
    end
  endtask

  task automatic test_div4();
    int cyc;
    int prev;
    @(negedge clk); flick4 = 1'b0;
    @(negedge clk); flick4 = 1'b1;
    cyc = 0; while (!busy4 && cyc < 10) begin @(negedge clk); cyc++; end
    for (int s = 1; s <= 8; s++) begin
      prev = int'(level4);
      cyc = 0;
      while (int'(level4) == prev && cyc < 20) begin @(negedge clk); cyc++; end
      n_tests++;
      if (cyc != 4 || int'(level4) != s) begin
        n_fail++; $display("FAIL div4_step: step %0d after %0d cycles at level %0d, required 4 cycles", s, cyc, level4);
      end
      if (s == 6) begin
        n_tests++;
        if (lamp4 !== 16'h003F) begin
          n_fail++; $display("FAIL div4_lamp: lamp %h, required 003f", lamp4);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    int cyc;
    exp_q.delete(); done_cnt = 0;
    push_ramp(0, 16); push_ramp(16, 6); push_ramp(6, 9);
    press_start();
    cyc = 0; while (!(phase_idx == 3'd2 && level == 5'd9) && cyc < 100) begin @(negedge clk); cyc++; end
    #2 reset = 1'b0;
    #1;
    n_tests++;
    if ({lamp, level, phase_idx, busy, done, lamp4, level4, phase4, busy4, done4} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: lamp %h level %0d phase %0d busy %b done %b, required all 0",
               lamp, level, phase_idx, busy, done);
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL reset_point: %0d steps missing before reset, required 0", exp_q.size());
    end
    @(negedge clk); #1 reset = 1'b1;
    repeat (20) @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || level !== 5'd0 || busy4 !== 1'b0 || done_cnt != 0) begin
      n_fail++; $display("FAIL no_restart: busy %b level %0d busy4 %b, required 0 0 0", busy, level, busy4);
    end
  endtask

  initial begin
    test_reset();
    test_full_run();
    test_kickback();
    test_kick_last();
    test_loop();
    test_div4();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bound_flasher_gen.md
# bound_flasher_gen

Parametrised lamp sequencer driving an N-lamp thermometer bar through a programmable table of alternating up/down sweeps, with a synchronised active-low `flick` start/kickback input, a step-rate prescaler and optional looping. It sits between the board button input and the lamp driver. It supersedes the fixed 16-lamp, 6-phase flasher, whose phase table, rate and end-of-run behaviour were hard-wired.

## Interface
- `N_LED`, 16: lamp count; level range 0..N_LED.
- `N_PHASE`, 6: phase count, even (even index = up sweep, odd = down sweep).
- `PH_TARGET`, {16,6,11,0,6,0}: packed N_PHASE×LW target levels, phase 0 in LSBs; LW = $clog2(N_LED+1).
- `KICK_MASK`, bits 0 and 6 set: (N_LED+1)-bit set of kickback levels.
- `DIV`, 1: clocks per step, ≥1.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `flick` in 1: active-low, asynchronous to `clk`; start in idle, kickback in down sweeps.
- `loop_en` in 1: 1 = restart at phase 0 after last phase instead of idling; sampled at last-phase completion.
- `lamp` out N_LED: thermometer; `lamp[k]=1` iff k < level.
- `level` out LW: current level.
- `phase_idx` out $clog2(N_PHASE): current phase.
- `busy` out 1: high in RUN.
- `done` out 1: one-cycle pulse at completion of a non-looping run.

## Operation
- States: IDLE, RUN. Reset: IDLE, level 0, phase 0, prescaler 0, all outputs 0.
- `flick` passes through a 2-flop synchroniser; `fl` = inverted synchronised value (1 = pressed).
- IDLE: `fl`=1 → RUN, phase 0, prescaler cleared. Otherwise hold.
- RUN: prescaler counts 0..DIV-1; a tick is a cycle with count = DIV-1. Level changes only on ticks.
- Up phase tick: level+1; if new level = target → phase+1.
- Down phase tick: next = level-1; level ← next. Then, priority order: (1) `KICK_MASK[next]` and `fl` → phase-1 (kickback to preceding up sweep); (2) next = target → phase+1. Kickback wins over completion, including on the last phase.
- Completion of phase N_PHASE-1: `loop_en`=1 → phase 0, stay RUN; else → IDLE, level 0, `done` pulse.
- `fl` is ignored in up phases and in RUN outside kick points; holding `flick` low through a kick point re-kicks on every arrival.
- Level never leaves 0..N_LED; table entries violating alternation or range are a parameter error (elaboration assertion).

## Timing
- `flick` low before edge k → `fl` valid after edge k+1 → RUN/`busy` at edge k+2.
- First step DIV cycles after RUN entry; then one step per DIV cycles, `lamp` and `level` registered, same edge.
- Default table without kickback: 54 steps to completion; `done` high and `busy` low in the same cycle, `done` for exactly one cycle.
- Async reset mid-run: all state and outputs to reset values immediately; synchroniser cleared (reads not pressed).

## Structure
- Package `bound_flasher_pkg`: state enum (IDLE, RUN), LW width function, default table constants.
- Sub-module `flick_sync`: 2-flop synchroniser with async active-low clear.
- Rest is one module: prescaler, level counter, phase register, table lookup.

## Test plan
- Defaults, DIV=1, one 1-cycle `flick` pulse: `busy` 2 cycles later; level 0→16→6→11→0→6→0; `done` after 54 steps; `lamp` = 16'h0000 at end.
- Hold `flick` low until level reaches 6 in phase 1: phase returns to 0, level climbs 6→16, then resumes phase 1.
- `flick` low on arrival at level 0 in phase 5: phase → 4, level rises to 6, no `done`.
- `loop_en`=1: after level 0 in phase 5, phase 0 next tick, `busy` stays 1, no `done`.
- DIV=4: level changes exactly every 4th cycle; `lamp` = 16'h003F when level = 6.
- Reset asserted at level 9, phase 2: `lamp`, `level`, `phase_idx`, `busy`, `done` all 0 immediately; no restart without new `flick`.
